// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: clips a rectangle to the screen and streams one palette
// write per granted VRAM cycle, pulsing o_done when the whole rectangle is written.
module vram_rect_fill #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 360,
    parameter int ADDR_WIDTH    = 18,
    parameter int DATA_WIDTH    = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [9:0]            i_x,
    input  logic [8:0]            i_y,
    input  logic [9:0]            i_w,
    input  logic [8:0]            i_h,
    input  logic [DATA_WIDTH-1:0] i_colour,
    input  logic                  i_wr_ok,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_write,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [9:0]            x_q, x_d;
    logic [8:0]            y_q, y_d;
    logic [9:0]            w_q, w_d;
    logic [8:0]            h_q, h_d;
    logic [DATA_WIDTH-1:0] colour_q, colour_d;
    logic [9:0]            cw_q, cw_d;
    logic [8:0]            ch_q, ch_d;
    logic [9:0]            col_q, col_d;
    logic [8:0]            row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [10:0]           cw_full, ch_full;
    logic [ADDR_WIDTH-1:0] base_addr;

    // Visible extent along one axis; 11-bit arithmetic so limit-origin never wraps.
    function automatic logic [10:0] clip_len(input logic [10:0] origin,
                                             input logic [10:0] extent,
                                             input logic [10:0] limit);
        logic [10:0] remain;
        if (origin >= limit) begin
            return 11'd0;
        end
        remain = limit - origin;
        return (extent < remain) ? extent : remain;
    endfunction

    always_comb begin
        cw_full   = clip_len({1'b0, x_q}, {1'b0, w_q}, 11'(SCREEN_WIDTH));
        ch_full   = clip_len({2'b00, y_q}, {2'b00, h_q}, 11'(SCREEN_HEIGHT));
        base_addr = ADDR_WIDTH'(y_q) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(x_q);
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        colour_d   = colour_q;
        cw_d       = cw_q;
        ch_d       = ch_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    x_d      = i_x;
                    y_d      = i_y;
                    w_d      = i_w;
                    h_d      = i_h;
                    colour_d = i_colour;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                cw_d       = cw_full[9:0];
                ch_d       = ch_full[8:0];
                addr_d     = base_addr;
                row_base_d = base_addr;
                col_d      = 10'd0;
                row_d      = 9'd0;
                state_d    = (cw_full == 11'd0 || ch_full == 11'd0) ? S_DONE : S_FILL;
            end
            S_FILL: begin
                // Everything holds while the arbiter withholds the write slot.
                if (o_write) begin
                    if (col_q < cw_q - 10'd1) begin
                        col_d  = col_q + 10'd1;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end else if (row_q < ch_q - 9'd1) begin
                        col_d      = 10'd0;
                        row_d      = row_q + 9'd1;
                        row_base_d = row_base_q + ADDR_WIDTH'(SCREEN_WIDTH);
                        addr_d     = row_base_q + ADDR_WIDTH'(SCREEN_WIDTH);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            colour_q   <= '0;
            cw_q       <= '0;
            ch_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            colour_q   <= colour_d;
            cw_q       <= cw_d;
            ch_q       <= ch_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    // Write enable is combinational so an async reset kills it without a clock edge.
    assign o_write = (state_q == S_FILL) && i_wr_ok;
    assign o_done  = (state_q == S_DONE);
    assign o_busy  = (state_q != S_IDLE);
    assign o_addr  = addr_q;
    assign o_data  = colour_q;

endmodule

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
- Drawing engine upstream of the VRAM frame buffer (sram, 640x360, 6-bit palette indices).
- Accepts one rectangle command (origin, size, palette index) and writes that index into every covered VRAM location, one pixel per granted cycle.
- Clips the rectangle to the screen.
- Signals completion with a single-cycle done pulse. The display read path is untouched; an external arbiter grants write cycles via i_wr_ok.

Parameters:
- SCREEN_WIDTH, 640, pixels per line; also the VRAM row stride.
- SCREEN_HEIGHT, 360, lines per frame.
- ADDR_WIDTH, 18, VRAM address width; 2^18 > 640*360.
- DATA_WIDTH, 6, palette index bits per pixel.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  command strobe; sampled only in IDLE.
- i_x  in  10  left column of the rectangle.
- i_y  in  9  top row of the rectangle.
- i_w  in  10  width in pixels.
- i_h  in  9  height in pixels.
- i_colour  in  DATA_WIDTH  palette index to write.
- i_wr_ok  in  1  VRAM write slot granted this cycle.
- o_busy  out  1  high from the cycle after start is accepted until DONE completes.
- o_done  out  1  one-cycle pulse at command completion.
- o_write  out  1  VRAM write enable.
- o_addr  out  ADDR_WIDTH  VRAM write address.
- o_data  out  DATA_WIDTH  VRAM write data.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE.
  - o_busy=0, o_done=0, o_addr=0, o_data=0.
  - o_write drops to 0 immediately, without waiting for a clock edge.
- States:
  - IDLE: i_start=1 latches x, y, w, h and colour, then goes to SETUP. i_start=0 stays in IDLE.
  - SETUP (1 cycle): computes clipped sizes and the base address.
    - cw = min(w, SCREEN_WIDTH-x); ch = min(h, SCREEN_HEIGHT-y).
    - cw=0 if x>=SCREEN_WIDTH; ch=0 if y>=SCREEN_HEIGHT.
    - Intermediate sums are 11 bits wide, so there is no wrap.
    - Loads o_addr = y*SCREEN_WIDTH + x, row_base = o_addr, col=0, row=0.
    - If cw==0 or ch==0, go to DONE. Otherwise go to FILL.
  - FILL:
    - o_write = i_wr_ok, combinational and gated by state==FILL.
    - Counters advance only on cycles where o_write=1.
    - If col<cw-1: col++, o_addr++.
    - Else, if row<ch-1: col=0, row++, row_base += SCREEN_WIDTH, o_addr = row_base + SCREEN_WIDTH.
    - Else (last pixel written): go to DONE.
    - i_wr_ok=0 stalls with all registers held; the stall length is unbounded.
  - DONE (1 cycle): o_done=1, then IDLE.
- o_busy = (state != IDLE).
- o_data = latched colour for the whole command.
- i_start while busy: ignored; no queueing.
- Command inputs are sampled only on the accepting edge. Later changes to them have no effect on the running command.
- Write count is exactly cw*ch. No address is ever >= SCREEN_WIDTH*SCREEN_HEIGHT.
- Latency:
  - Start edge to first o_write opportunity: 2 cycles.
  - Back-to-back commands: the next i_start can be accepted in the cycle after o_done.
- Reset mid-FILL: stops immediately. Pixels already written stay written, and no o_done pulse is produced.

Test Plan:
- Start x=10, y=5, w=3, h=2, colour=0x2A, i_wr_ok=1 constant -> 6 writes of 0x2A to addresses 3210, 3211, 3212, 3850, 3851, 3852 on consecutive cycles; then one-cycle o_done; o_busy falls the cycle after.
- Same command with i_wr_ok toggling 1,0,1,0... -> same 6 addresses in the same order; 12-cycle FILL; o_addr held during the 0 cycles.
- Start x=638, y=358, w=5, h=5 -> clipped to 2x2: writes to 229758, 229759, 230398, 230399 only.
- Start with w=0, or with x=700 -> no o_write; o_done pulses 2 cycles after the start edge.
- Pulse i_start with different arguments during FILL -> ignored; write count and addresses match the first command only.
- Assert i_rst after 3 of 6 writes -> o_write=0 asynchronously; o_busy=0; no o_done. A new start after reset completes normally.
